// File: rtl/dmem_ddr_bridge_if.sv
// Core-side and ram-side bundles for dmem_ddr_bridge.
// The core is master of dmem_core_if; the bridge is master of dmem_mem_if.

interface dmem_core_if;
   logic        core_en;
   logic        core_we;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        core_rvalid;
   logic        core_stall;
   logic        rd_err;

   modport master (
      output core_en, core_we, core_addr, core_wdata,
      input  core_rdata, core_rvalid, core_stall, rd_err
   );

   modport slave (
      input  core_en, core_we, core_addr, core_wdata,
      output core_rdata, core_rvalid, core_stall, rd_err
   );
endinterface

interface dmem_mem_if;
   logic [28:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write_req;
   logic        mem_read_req;
   logic        mem_write_ready;
   logic        mem_read_ready;
   logic        mem_read_data_valid;
   logic [31:0] mem_read_data;
   logic        mem_stall;

   modport master (
      output mem_addr, mem_wdata, mem_write_req, mem_read_req,
      input  mem_write_ready, mem_read_ready, mem_read_data_valid, mem_read_data, mem_stall
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_write_req, mem_read_req,
      output mem_write_ready, mem_read_ready, mem_read_data_valid, mem_read_data, mem_stall
   );
endinterface

// File: rtl/dmem_ddr_bridge.sv
// Core data-memory to DDR3 ram bridge: posted-write buffer, serialised loads, read watchdog.
// Define WBUF_FWD_EN to let loads hit in the write buffer instead of draining it.

module dmem_ddr_bridge #(
   parameter int WBUF_DEPTH = 4,
   parameter int RD_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   dmem_core_if.slave core,
   dmem_mem_if.master mem
);

   localparam int          PTR_W        = $clog2(WBUF_DEPTH);
   localparam int          CNT_W        = PTR_W + 1;
   localparam int          WD_W         = $clog2(RD_TIMEOUT + 1);
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD;

   typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;

   state_t           state, state_nxt;
   logic [26:0]      buf_addr [WBUF_DEPTH];
   logic [31:0]      buf_data [WBUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             fifo_empty, fifo_full;
   logic             store_req, load_req, push, pop, drain_en, rd_accept;
   logic [26:0]      ld_addr;
   logic [WD_W-1:0]  wdog;
   logic             wdog_expired;
   logic             addr_unused;

   assign addr_unused  = ^{core.core_addr[31:29], core.core_addr[1:0]};

   assign fifo_empty   = (count == '0);
   assign fifo_full    = (count == CNT_W'(WBUF_DEPTH));
   assign store_req    = (state == IDLE) && core.core_en && core.core_we;
   assign load_req     = (state == IDLE) && core.core_en && !core.core_we;
   assign push         = store_req && !fifo_full;
   assign wdog_expired = (wdog == WD_W'(RD_TIMEOUT - 1));

`ifdef WBUF_FWD_EN
   // A forwarded load returns through RD_DONE while the buffer keeps draining,
   // so the pending write request must stay up there too.
   assign drain_en = !fifo_empty && (state == IDLE || state == DRAIN || state == RD_DONE);

   logic        fwd_hit;
   logic [31:0] fwd_data;

   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         if ((CNT_W'(i) < count) &&
             (buf_addr[rd_ptr + PTR_W'(i)] == core.core_addr[28:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = buf_data[rd_ptr + PTR_W'(i)];
         end
      end
   end
`else
   assign drain_en = !fifo_empty && (state == IDLE || state == DRAIN);
`endif

   assign pop       = drain_en && mem.mem_write_ready && !mem.mem_stall;
   assign rd_accept = (state == RD_REQ) && mem.mem_read_ready && !mem.mem_stall;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load_req) state_nxt = fifo_empty ? RD_REQ : DRAIN;
`ifdef WBUF_FWD_EN
            if (load_req && fwd_hit) state_nxt = RD_DONE;
`endif
         end
         DRAIN:   if (fifo_empty) state_nxt = RD_REQ;
         RD_REQ:  if (rd_accept) state_nxt = RD_WAIT;
         RD_WAIT: if (mem.mem_read_data_valid || wdog_expired) state_nxt = RD_DONE;
         RD_DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      core.core_stall   = 1'b0;
      core.core_rvalid  = 1'b0;
      mem.mem_write_req = 1'b0;
      mem.mem_read_req  = 1'b0;
      mem.mem_addr      = '0;
      mem.mem_wdata     = '0;
      case (state)
         IDLE:                   core.core_stall  = load_req || (store_req && fifo_full);
         DRAIN, RD_REQ, RD_WAIT: core.core_stall  = 1'b1;
         RD_DONE:                core.core_rvalid = 1'b1;
         default:                core.core_stall  = 1'b0;
      endcase
      if (state == RD_REQ) begin
         mem.mem_read_req = 1'b1;
         mem.mem_addr     = {ld_addr, 2'b00};
      end else if (drain_en) begin
         mem.mem_write_req = 1'b1;
         mem.mem_addr      = {buf_addr[rd_ptr], 2'b00};
         mem.mem_wdata     = buf_data[rd_ptr];
      end
   end

   // A push is never allowed while full, even against a same-cycle pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: buffer storage has no reset; entries are only read when count says valid.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_addr[wr_ptr] <= core.core_addr[28:2];
         buf_data[wr_ptr] <= core.core_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_addr         <= '0;
         wdog            <= '0;
         core.core_rdata <= '0;
         core.rd_err     <= 1'b0;
      end else begin
         if (load_req) ld_addr <= core.core_addr[28:2];
         wdog <= (state == RD_WAIT) ? wdog + 1'b1 : '0;
         // Data arriving on the final watchdog cycle still counts as in time.
         if (state == RD_WAIT) begin
            if (mem.mem_read_data_valid) begin
               core.core_rdata <= mem.mem_read_data;
            end else if (wdog_expired) begin
               core.core_rdata <= TIMEOUT_DATA;
               core.rd_err     <= 1'b1;
            end
         end
`ifdef WBUF_FWD_EN
         if (load_req && fwd_hit) core.core_rdata <= fwd_data;
`endif
      end
   end

endmodule

// File: doc/dmem_ddr_bridge.md
Name: dmem_ddr_bridge

Overview:
- Upstream of the DDR3 `ram` wrapper; converts core data-memory accesses (addr/wdata/en/we) into the ram request/ready interface.
- Posts stores into a small write buffer so the core does not stall on writes.
- Serialises loads behind buffered stores, stalls the core until read data returns, and bounds every read with a watchdog.

Parameters:
WBUF_DEPTH, 4, write-buffer entries (power of two, >=2)
RD_TIMEOUT, 1024, max cycles in RD_WAIT before the read is aborted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
core_en  in  1  core access valid
core_we  in  1  1=store, 0=load
core_addr  in  32  byte address; bits[28:2] used, others ignored
core_wdata  in  32  store data
core_rdata  out  32  load data, valid with core_rvalid
core_rvalid  out  1  one-cycle load completion pulse
core_stall  out  1  core must hold current request
rd_err  out  1  sticky: a read timed out; cleared by reset only
mem_addr  out  29  to ram addr_in, always {addr[28:2],2'b00}
mem_wdata  out  32  to ram write_data_in
mem_write_req  out  1  to ram write_req
mem_read_req  out  1  to ram read_req
mem_write_ready  in  1  from ram write_ready
mem_read_ready  in  1  from ram read_ready
mem_read_data_valid  in  1  from ram read_data_valid
mem_read_data  in  32  from ram read_data_out
mem_stall  in  1  from ram please_stall_everything

Behaviour:
- Reset (async, rst_n=0): FIFO empty, FSM=IDLE, watchdog=0, all outputs 0, rd_err=0.
- Ram handshake: a request is accepted in a cycle where req=1, the matching ready=1 and mem_stall=0. Until acceptance, mem_addr/mem_wdata/req are held stable.
- Store path:
  - In IDLE, core_en&core_we with FIFO not full: enqueue {addr,wdata} at the clock edge; core_stall=0.
  - FIFO full: core_stall=1 (combinational), no enqueue. An enqueue is not permitted against a same-cycle pop when full.
  - In any state other than IDLE, stores are stalled.
- Drain:
  - When FIFO is non-empty and FSM is IDLE or DRAIN, the head is driven on mem_addr/mem_wdata with mem_write_req=1. Pop on acceptance.
  - Pointers wrap modulo WBUF_DEPTH. Count is 0..WBUF_DEPTH.
- Load FSM, states IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE:
  - IDLE: core_en&~core_we latches the address and asserts core_stall=1 combinationally in that cycle. Next state is DRAIN if FIFO is non-empty, else RD_REQ.
  - DRAIN: core_stall=1; go to RD_REQ the cycle after the FIFO becomes empty.
  - RD_REQ: mem_read_req=1 with the latched address; go to RD_WAIT on acceptance. mem_write_req=0.
  - RD_WAIT: watchdog increments each cycle.
    - On mem_read_data_valid, capture mem_read_data into core_rdata and go to RD_DONE.
    - If the watchdog reaches RD_TIMEOUT, core_rdata=32'hDEAD_DEAD, rd_err=1, go to RD_DONE.
    - A data_valid that arrives after a timeout is ignored.
  - RD_DONE: core_rvalid=1, core_stall=0 for exactly one cycle; return to IDLE. The core drops or changes its request on this edge.
- core_stall=1 in DRAIN/RD_REQ/RD_WAIT. core_rdata holds its last value outside RD_DONE.
- mem_read_data_valid outside RD_WAIT is ignored.
- Minimum load latency with an empty FIFO and an immediate ram ack: IDLE→RD_REQ→RD_WAIT→(data)→RD_DONE, so the core stalls at least 3 cycles.

Optional Feature:
- Macro: WBUF_FWD_EN.
- Defined: a load in IDLE whose word address matches any FIFO entry goes straight to RD_DONE next cycle with the youngest matching entry's data. There is no drain and no ram read; the FIFO continues draining in parallel. A miss follows the normal path.
- Undefined: every load drains the FIFO fully before RD_REQ, with no comparators.

Test Plan:
- Store 0xDEADBEEF to 0x0,0x4,0x8 with ram always ready → no core_stall; three mem_write_req accepts in order with mem_addr 0x0,0x4,0x8.
- Hold mem_write_ready=0 and issue 5 stores → stall on the 5th store (WBUF_DEPTH=4). Release ready → 4 writes drain in order, then the 5th store is accepted.
- Store 0x12345678 to 0x40, then load 0x40, ram returns the written value after 10 cycles → write accepted before mem_read_req; core_rvalid pulse with core_rdata=0x12345678.
- Load 0x70000000 → mem_addr=0x10000000. Hold mem_stall=1 for 20 cycles → mem_read_req held with stable address; accepted only after mem_stall falls.
- Load with no mem_read_data_valid → after RD_TIMEOUT cycles, core_rdata=0xDEADDEAD, rd_err=1, core_rvalid=1. A later valid is ignored.
- rst_n low during RD_WAIT with 2 FIFO entries → outputs 0, FIFO empty. A post-reset data_valid produces no core_rvalid.
